// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - rebuilds raster position from hs/vs/blank and monitors the video timing
// Lock is declared after LOCK_FRAMES clean frames; sync and blank violations latch into sticky error bits.
module vga_sync_decoder #(
   parameter int H_VIS       = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_VIS       = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_pixel_en,
   input  logic        i_hs,
   input  logic        i_vs,
   input  logic        i_blank,
   input  logic        i_err_clr,
   output logic [9:0]  o_rx_x,
   output logic [9:0]  o_rx_y,
   output logic        o_rx_active,
   output logic        o_locked,
   output logic        o_frame_start,
   output logic [15:0] o_frame_cnt,
   output logic        o_h_err,
   output logic        o_v_err,
   output logic        o_b_err
);

   localparam logic [9:0] C_H_VIS    = 10'(H_VIS);
   localparam logic [9:0] C_V_VIS    = 10'(V_VIS);
   localparam logic [9:0] C_H_SYNC   = 10'(H_SYNC);
   localparam logic [9:0] C_V_SYNC   = 10'(V_SYNC);
   localparam logic [9:0] C_H_TOTAL  = 10'(H_VIS + H_FP + H_SYNC + H_BP);
   localparam logic [9:0] C_V_TOTAL  = 10'(V_VIS + V_FP + V_SYNC + V_BP);
   localparam logic [9:0] C_HS_START = 10'(H_VIS + H_FP);
   localparam logic [9:0] C_VS_START = 10'(V_VIS + V_FP);
   localparam logic [3:0] C_LOCK     = 4'(LOCK_FRAMES);

   typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [3:0]  r_good_cnt;
   logic [3:0]  w_good_next;
   logic        r_hs_q;
   logic        r_vs_q;
   logic [9:0]  r_x;
   logic [9:0]  r_y;
   logic [9:0]  r_pix_cnt;
   logic [9:0]  r_hs_low_cnt;
   logic [9:0]  r_line_cnt;
   logic [9:0]  r_vs_low_cnt;
   logic        r_h_seen;
   logic        r_frame_start;
   logic [15:0] r_frame_cnt;
   logic        r_h_err;
   logic        r_v_err;
   logic        r_b_err;

   logic        w_hs_fall;
   logic        w_hs_rise;
   logic        w_vs_fall;
   logic        w_vs_rise;
   logic        w_x_wrap;
   logic [9:0]  w_x_next;
   logic [9:0]  w_y_next;
   logic        w_vis_next;
   logic        w_h_viol;
   logic        w_v_viol;
   logic        w_b_viol;
   logic        w_checking;

   // Saturating so a dead sync input never wraps around into a false period match.
   function automatic logic [9:0] f_sat_inc(input logic [9:0] v);
      return (v == 10'h3FF) ? v : v + 10'd1;
   endfunction

   assign w_hs_fall = i_pixel_en & r_hs_q & ~i_hs;
   assign w_hs_rise = i_pixel_en & ~r_hs_q & i_hs;
   assign w_vs_fall = i_pixel_en & r_vs_q & ~i_vs;
   assign w_vs_rise = i_pixel_en & ~r_vs_q & i_vs;

   assign w_x_wrap   = ~w_hs_fall & (r_x >= C_H_TOTAL - 10'd1);
   assign w_x_next   = w_hs_fall ? C_HS_START : (w_x_wrap ? 10'd0 : r_x + 10'd1);
   assign w_y_next   = w_vs_fall ? C_VS_START :
                       (w_x_wrap ? ((r_y >= C_V_TOTAL - 10'd1) ? 10'd0 : r_y + 10'd1) : r_y);
   assign w_vis_next = (w_x_next < C_H_VIS) & (w_y_next < C_V_VIS);

   assign w_h_viol = (w_hs_fall & (r_pix_cnt != C_H_TOTAL))
                   | (w_hs_rise & (r_hs_low_cnt != C_H_SYNC))
                   | (i_pixel_en & ~w_hs_fall & (r_pix_cnt == 10'h3FE));
   assign w_v_viol = (w_vs_fall & ((r_line_cnt != C_V_TOTAL) | (w_x_next != 10'd0)))
                   | (w_vs_rise & (r_vs_low_cnt != C_V_SYNC));
   assign w_b_viol = i_pixel_en & (r_state == LOCKED) & (i_blank != w_vis_next);
   assign w_checking = (r_state != SEARCH);

   always_comb begin
      w_state_next = r_state;
      w_good_next  = r_good_cnt;
      case (r_state)
         SEARCH: begin
            w_good_next = 4'd0;
            if (w_vs_fall & r_h_seen) w_state_next = ACQUIRE;
         end
         ACQUIRE: begin
            if (w_h_viol | w_v_viol) begin
               w_state_next = SEARCH;
               w_good_next  = 4'd0;
            end else if (w_vs_fall) begin
               w_good_next = r_good_cnt + 4'd1;
               if (r_good_cnt + 4'd1 >= C_LOCK) w_state_next = LOCKED;
            end
         end
         LOCKED: begin
            if (w_h_viol | w_v_viol) begin
               w_state_next = SEARCH;
               w_good_next  = 4'd0;
            end
         end
         default: begin
            w_state_next = SEARCH;
            w_good_next  = 4'd0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= SEARCH;
         r_good_cnt <= 4'd0;
      end else if (i_pixel_en) begin
         r_state    <= w_state_next;
         r_good_cnt <= w_good_next;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_hs_q        <= 1'b0;
         r_vs_q        <= 1'b0;
         r_x           <= 10'd0;
         r_y           <= 10'd0;
         r_pix_cnt     <= 10'd0;
         r_hs_low_cnt  <= 10'd0;
         r_line_cnt    <= 10'd0;
         r_vs_low_cnt  <= 10'd0;
         r_h_seen      <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_cnt   <= 16'd0;
         r_h_err       <= 1'b0;
         r_v_err       <= 1'b0;
         r_b_err       <= 1'b0;
      end else begin
         r_frame_start <= w_vs_fall & (w_state_next == LOCKED);
         if (i_pixel_en) begin
            r_hs_q       <= i_hs;
            r_vs_q       <= i_vs;
            r_x          <= w_x_next;
            r_y          <= w_y_next;
            r_pix_cnt    <= w_hs_fall ? 10'd1 : f_sat_inc(r_pix_cnt);
            r_hs_low_cnt <= w_hs_fall ? 10'd1 : (~i_hs ? f_sat_inc(r_hs_low_cnt) : r_hs_low_cnt);
            // Line and vs-low counters are measured in hs falls.
            if (w_vs_fall) begin
               r_line_cnt   <= {9'd0, w_hs_fall};
               r_vs_low_cnt <= {9'd0, w_hs_fall};
            end else if (w_hs_fall) begin
               r_line_cnt   <= f_sat_inc(r_line_cnt);
               r_vs_low_cnt <= ~i_vs ? f_sat_inc(r_vs_low_cnt) : r_vs_low_cnt;
            end
            r_h_seen <= (w_state_next != SEARCH) ? 1'b0 : (r_h_seen | w_hs_fall);
            if (w_vs_fall & (w_state_next == LOCKED)) r_frame_cnt <= r_frame_cnt + 16'd1;
            r_h_err <= (w_h_viol & w_checking) | (r_h_err & ~i_err_clr);
            r_v_err <= (w_v_viol & w_checking) | (r_v_err & ~i_err_clr);
            r_b_err <= w_b_viol | (r_b_err & ~i_err_clr);
         end
      end
   end

   assign o_rx_x        = r_x;
   assign o_rx_y        = r_y;
   assign o_locked      = (r_state == LOCKED);
   assign o_rx_active   = o_locked & (r_x < C_H_VIS) & (r_y < C_V_VIS);
   assign o_frame_start = r_frame_start;
   assign o_frame_cnt   = r_frame_cnt;
   assign o_h_err       = r_h_err;
   assign o_v_err       = r_v_err;
   assign o_b_err       = r_b_err;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - directed bench for vga_sync_decoder on a reduced 32x16 raster
// Raster: 16 visible px, hs low at x 20..25, 32 px/line; 8 visible lines, vs low on lines 10..11, 16 lines/frame.
module tb_vga_sync_decoder;

   logic        clk = 1'b0;
   logic        rst, pe, hs, vs, blank, clr;
   logic [9:0]  rx_x, rx_y;
   logic        rx_active, locked, fs, h_err, v_err, b_err;
   logic [15:0] fcnt;

   int n_tests = 0;
   int n_fail  = 0;
   int hc = 0, vc = 0, last_hc = 0, last_vc = 0;
   int stretch_line = -1, vs_lines = 2, gx = -1, gy = -1;
   bit dead = 1'b0;
   logic fs_seen, fs_after;

   always #5 clk = ~clk;

   vga_sync_decoder #(
      .H_VIS(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
      .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(4),
      .LOCK_FRAMES(2)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_pixel_en(pe), .i_hs(hs), .i_vs(vs),
      .i_blank(blank), .i_err_clr(clr),
      .o_rx_x(rx_x), .o_rx_y(rx_y), .o_rx_active(rx_active), .o_locked(locked),
      .o_frame_start(fs), .o_frame_cnt(fcnt),
      .o_h_err(h_err), .o_v_err(v_err), .o_b_err(b_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One pixel: a pixel_en clock followed by an idle clock.
   task automatic pix(input bit c);
      int len;
      hs    = dead ? 1'b1 : !(hc >= 20 && hc < 26);
      vs    = dead ? 1'b1 : !(vc >= 10 && vc < 10 + vs_lines);
      blank = (hc < 16 && vc < 8) ^ (hc == gx && vc == gy);
      pe = 1'b1; clr = c;
      tick();
      fs_seen = fs;
      pe = 1'b0; clr = 1'b0;
      tick();
      fs_after = fs;
      last_hc = hc; last_vc = vc;
      if (hc == gx && vc == gy) begin gx = -1; gy = -1; end
      len = (vc == stretch_line) ? 33 : 32;
      hc++;
      if (hc >= len) begin
         if (vc == stretch_line) stretch_line = -1;
         hc = 0;
         vc++;
         if (vc == 16) begin vc = 0; vs_lines = 2; end
      end
   endtask

   task automatic run_to(input int x, input int y);
      int n = 0;
      bit hit = 1'b0;
      while (!hit && n < 2048) begin
         pix(1'b0);
         n++;
         hit = (last_hc == x && last_vc == y);
      end
      if (!hit) chk("run_to_bound", 32'(last_hc * 1000 + last_vc), 32'(x * 1000 + y));
   endtask

   task automatic relock();
      run_to(0, 10);
      run_to(0, 10);
      chk("relock_pre", 32'(locked), 32'd0);
      run_to(0, 10);
      chk("relock", 32'(locked), 32'd1);
   endtask

   initial begin
      rst = 1'b1; pe = 1'b0; hs = 1'b1; vs = 1'b1; blank = 1'b0; clr = 1'b0;
      tick(); tick();
      chk("rst_x", 32'(rx_x), 32'd0);
      chk("rst_y", 32'(rx_y), 32'd0);
      chk("rst_flags", 32'({locked, rx_active, fs, h_err, v_err, b_err}), 32'd0);
      chk("rst_fcnt", 32'(fcnt), 32'd0);
      rst = 1'b0;

      // 1: lock on the third vs fall, recovered position tracks the raster
      run_to(0, 10);
      chk("t1_vs1_lock", 32'(locked), 32'd0);
      run_to(0, 10);
      chk("t1_vs2_lock", 32'(locked), 32'd0);
      run_to(0, 10);
      chk("t1_vs3_lock", 32'(locked), 32'd1);
      chk("t1_fs", 32'(fs_seen), 32'd1);
      chk("t1_fs_width", 32'(fs_after), 32'd0);
      chk("t1_fcnt", 32'(fcnt), 32'd1);
      chk("t1_xy_vs", 32'({rx_x, rx_y}), 32'({10'd0, 10'd10}));
      run_to(5, 3);
      chk("t1_xy", 32'({rx_x, rx_y}), 32'({10'd5, 10'd3}));
      chk("t1_active", 32'(rx_active), 32'd1);
      run_to(16, 3);
      chk("t1_active_edge", 32'(rx_active), 32'd0);
      chk("t1_errs", 32'({h_err, v_err, b_err}), 32'd0);

      // 2: line 12 stretched to 33 px, caught at the following hs fall
      stretch_line = 12;
      run_to(19, 13);
      chk("t2_pre", 32'({locked, h_err}), 32'b10);
      pix(1'b0);
      chk("t2_h_err", 32'(h_err), 32'd1);
      chk("t2_unlock", 32'(locked), 32'd0);
      relock();
      chk("t2_h_sticky", 32'(h_err), 32'd1);
      pix(1'b1);
      chk("t2_clr", 32'({h_err, v_err, b_err}), 32'd0);

      // 3: vs held low for 3 lines, caught at vs rise
      vs_lines = 3;
      run_to(31, 12);
      chk("t3_pre", 32'({locked, v_err}), 32'b10);
      pix(1'b0);
      chk("t3_v_err", 32'({locked, v_err}), 32'b01);
      pix(1'b1);
      chk("t3_clr", 32'(v_err), 32'd0);
      relock();

      // 4: blank glitch in the horizontal blanking of a visible line
      gx = 18; gy = 3;
      run_to(17, 3);
      chk("t4_pre", 32'(b_err), 32'd0);
      pix(1'b0);
      chk("t4_b_err", 32'({locked, b_err}), 32'b11);
      run_to(0, 10);
      chk("t4_fs", 32'({locked, fs_seen}), 32'b11);
      chk("t4_fcnt", 32'(fcnt), 32'd5);

      // 5: asynchronous reset in the middle of a line
      run_to(9, 11);
      rst = 1'b1;
      #2;
      chk("t5_rst_xy", 32'({rx_x, rx_y}), 32'd0);
      chk("t5_rst_flags", 32'({locked, fs, h_err, v_err, b_err}), 32'd0);
      chk("t5_rst_fcnt", 32'(fcnt), 32'd0);
      #2;
      rst = 1'b0;
      relock();
      chk("t5_fcnt", 32'(fcnt), 32'd1);

      // 6: pixel_en idle while locked, then err_clr collides with a new h violation
      run_to(5, 3);
      for (int i = 0; i < 1000; i++) begin
         hs = 1'($urandom); vs = 1'($urandom); blank = 1'($urandom);
         tick();
      end
      chk("t6_frozen_xy", 32'({rx_x, rx_y}), 32'({10'd5, 10'd3}));
      chk("t6_frozen_flags", 32'({locked, rx_active, h_err, v_err, b_err}), 32'b11000);
      chk("t6_frozen_fcnt", 32'(fcnt), 32'd1);
      stretch_line = 12;
      run_to(19, 13);
      pix(1'b1);
      chk("t6_set_wins", 32'({locked, h_err}), 32'b01);
      pix(1'b0);
      chk("t6_sticky", 32'(h_err), 32'd1);
      pix(1'b1);
      chk("t6_clr", 32'(h_err), 32'd0);

      // 7: dead sync, timeout when the pixel counter reaches 1023
      relock();
      run_to(31, 2);
      dead = 1'b1;
      repeat (1010) pix(1'b0);
      chk("t7_pre", 32'({locked, h_err}), 32'b10);
      pix(1'b0);
      chk("t7_timeout", 32'({locked, h_err}), 32'b01);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
